// File: rtl/rx_chan_serializer.sv
// rx_chan_serializer: captures one multi-channel sample set per rxstrobe and
// streams it out one channel word per cycle, with a settings-bus mode register
// selecting pass-through, counter or constant-pattern words.
module rx_chan_serializer #(
    parameter int         NCHAN = 2,
    parameter int         WIDTH = 16,
    parameter logic [6:0] ADDR  = 7'd0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   serial_strobe,
    input  logic [6:0]             serial_addr,
    input  logic [31:0]            serial_data,
    input  logic                   rxstrobe,
    input  logic [NCHAN*WIDTH-1:0] ch_in,
    input  logic [3:0]             numchan,
    input  logic                   clear_status,
    output logic [WIDTH-1:0]       out_data,
    output logic [2:0]             out_chan,
    output logic                   out_valid,
    output logic                   out_first,
    output logic                   overrun
);

    localparam logic [3:0] NCHAN_C = 4'(NCHAN);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q;
    logic [1:0]             mode_q;
    logic [WIDTH-1:0]       pattern_q, pattern_d;
    logic [WIDTH-1:0]       cnt_q;
    logic [2:0]             idx_q, idx_d;
    logic [3:0]             nc_q, nc_d;
    logic [7:0][WIDTH-1:0]  hold_q;
    logic [7:0][WIDTH-1:0]  word;
    logic [WIDTH-1:0]       out_data_q;
    logic [2:0]             out_chan_q;
    logic                   out_valid_q, out_first_q, overrun_q;
    logic                   last_word, accept, ovr_evt;
    logic                   unused_sd;

    // Only the mode bits and the pattern field of the write word are decoded.
    assign unused_sd = ^serial_data;

    // Pattern field is the top half of the write word, fitted to WIDTH.
    if (WIDTH <= 16) begin : g_pat_narrow
        assign pattern_d = serial_data[16 +: WIDTH];
    end else begin : g_pat_wide
        assign pattern_d = {{(WIDTH-16){1'b0}}, serial_data[31:16]};
    end

    // Candidate burst words; slots beyond NCHAN are padding and never emitted.
    for (genvar k = 0; k < 8; k++) begin : g_word
        if (k < NCHAN) begin : g_live
            assign word[k] = (mode_q == 2'd1) ? cnt_q + WIDTH'(k) :
                             (mode_q == 2'd2) ? pattern_q :
                                                ch_in[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign word[k] = '0;
        end
    end

    // Effective channel count, clamped to 1..NCHAN.
    always_comb begin
        nc_d = numchan;
        if (numchan == 4'd0)         nc_d = 4'd1;
        else if (numchan > NCHAN_C)  nc_d = NCHAN_C;
    end

    // A new sample set is only taken when the word on the outputs is the last
    // of its burst (or nothing is being sent); otherwise it is an overrun.
    assign idx_d     = idx_q + 3'd1;
    assign last_word = ({1'b0, idx_q} == nc_q - 4'd1);
    assign accept    = enable && rxstrobe && (state_q == IDLE || last_word);
    assign ovr_evt   = enable && rxstrobe && (state_q == SHIFT) && !last_word;

    // Settings register: mode and constant pattern.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q    <= 2'd0;
            pattern_q <= '0;
        end else if (serial_strobe && serial_addr == ADDR) begin
            mode_q    <= serial_data[1:0];
            pattern_q <= pattern_d;
        end
    end

    // Capture/shift FSM; outputs are registered so word 0 appears the cycle
    // after the accepting strobe, and the outputs always show hold[idx].
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            nc_q        <= 4'd1;
            cnt_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_chan_q  <= 3'd0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (clear_status) overrun_q <= 1'b0;
            if (ovr_evt)      overrun_q <= 1'b1;

            if (!enable) begin
                state_q     <= IDLE;
                idx_q       <= 3'd0;
                cnt_q       <= '0;
                out_valid_q <= 1'b0;
                out_first_q <= 1'b0;
            end else if (accept) begin
                state_q     <= SHIFT;
                idx_q       <= 3'd0;
                nc_q        <= nc_d;
                hold_q      <= word;
                cnt_q       <= cnt_q + WIDTH'(nc_d);
                out_data_q  <= word[0];
                out_chan_q  <= 3'd0;
                out_valid_q <= 1'b1;
                out_first_q <= 1'b1;
            end else if (state_q == SHIFT) begin
                if (last_word) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    out_first_q <= 1'b0;
                end else begin
                    idx_q       <= idx_d;
                    out_data_q  <= hold_q[idx_d];
                    out_chan_q  <= idx_d;
                    out_first_q <= 1'b0;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/rx_chan_serializer.md
RX_CHAN_SERIALIZER -- requirements
Module: rx_chan_serializer

Interface
REQ-001 SHALL have parameter NCHAN, default 2, number of input channels (legal range 1..8).
REQ-002 SHALL have parameter WIDTH, default 16, sample width in bits.
REQ-003 SHALL have parameter ADDR, default 7'd0, serial bus address of the mode register.
REQ-004 SHALL have port: clock  in  1  sample-domain clock; all logic on the rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port: enable  in  1  block enable.
REQ-007 SHALL have ports: serial_strobe in 1, serial_addr in 7, serial_data in 32; these form the settings write bus.
REQ-008 SHALL have port: rxstrobe  in  1  one-cycle pulse marking a valid sample set on ch_in.
REQ-009 SHALL have port: ch_in  in  NCHAN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port: numchan  in  4  number of active channels.
REQ-011 SHALL have port: clear_status  in  1  clears the sticky overrun flag.
REQ-012 SHALL have ports: out_data out WIDTH; out_chan out 3; out_valid out 1; out_first out 1 (high on the channel-0 word); overrun out 1 (sticky).

Function
REQ-013 Mode register SHALL load on serial_strobe with serial_addr==ADDR: mode=serial_data[1:0], pattern=serial_data[31:16] (lower WIDTH bits if WIDTH<16, zero-extended if WIDTH>16).
REQ-014 Modes SHALL be: 0 pass (word k = ch_in channel k); 1 counter (word k = cnt+k mod 2^WIDTH); 2 constant (every word = pattern); 3 SHALL behave as 0.
REQ-015 Effective channel count nc SHALL be clamp(numchan,1,NCHAN), sampled at capture and held for the whole burst.
REQ-016 FSM SHALL have states IDLE and SHIFT.
REQ-017 IDLE with enable&rxstrobe SHALL capture all nc words into a holding register, set idx=0, and go to SHIFT.
REQ-018 In SHIFT, the block SHALL emit one word per cycle: out_valid=1, out_data=hold[idx], out_chan=idx, out_first=(idx==0).
REQ-019 First out_valid SHALL occur exactly 1 cycle after the accepting rxstrobe; a burst SHALL be nc consecutive cycles.
REQ-020 After the word with idx==nc-1, the block SHALL return to IDLE unless a new capture occurs on that cycle.
REQ-021 rxstrobe in SHIFT on the last-word cycle SHALL be accepted (capture, idx=0, stay in SHIFT), giving gap-free bursts.
REQ-022 rxstrobe in SHIFT on any non-last-word cycle SHALL set overrun=1 and drop the sample; the current burst SHALL continue unaffected.
REQ-023 cnt SHALL advance by nc on every accepted rxstrobe in every mode, wrapping mod 2^WIDTH.
REQ-024 cnt SHALL be held at 0 while enable=0.
REQ-025 enable=0 SHALL force IDLE on the next edge; out_valid SHALL be 0 from that cycle on; the partial burst SHALL be discarded.
REQ-026 clear_status SHALL clear overrun next cycle; a simultaneous new overrun event SHALL win (overrun=1).
REQ-027 rxstrobe with enable=0 SHALL be ignored and SHALL NOT set overrun.
REQ-028 outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 reset SHALL asynchronously force: state=IDLE, idx=0, cnt=0, mode=0, pattern=0, out_data=0, out_chan=0, out_valid=0, out_first=0, overrun=0.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no further out_valid; the first accepted rxstrobe after deassertion SHALL start a clean burst.

Verification
REQ-031 NCHAN=2, mode 0, ch_in={16'hBBBB,16'hAAAA}, rxstrobe at cycle t -> out_valid at t+1 (AAAA, chan 0, first=1) and t+2 (BBBB, chan 1), then 0.
REQ-032 Mode 1, nc=2, three rxstrobes spaced 4 cycles apart -> words 0,1,2,3,4,5; overrun=0.
REQ-033 nc=4, rxstrobe at t and t+2 -> second dropped, overrun=1 from t+3; clear_status at t+10 -> overrun=0 at t+11.
REQ-034 nc=2, rxstrobe every 2 cycles -> continuous out_valid, first toggles 1,0,1,0; overrun stays 0.
REQ-035 Mode 2 written with serial_data=32'h5A5A_0002 -> all words 16'h5A5A; numchan=0 -> single-word bursts; numchan=9 with NCHAN=2 -> 2-word bursts.
REQ-036 enable dropped at word 1 of a 4-word burst -> out_valid=0 from the next cycle; cnt=0; async reset pulse mid-burst -> all outputs 0 without a clock edge.
